// File: rtl/calc_keypad_scan.sv
// 4x4 active-low keypad scanner with debounce; emits one btn_valid pulse and
// an ASCII/control code per accepted press, with no auto-repeat while held.
`timescale 1ns/1ps
module calc_keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       btn_valid,
  output logic [7:0] btn_char,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       cand_row_q, cand_row_d;
  logic [1:0]       cand_col_q, cand_col_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       rel_cnt_q, rel_cnt_d;
  logic             btn_valid_q, btn_valid_d;
  logic [7:0]       btn_char_q, btn_char_d;
  logic             key_held_q, key_held_d;

  logic             tick;
  logic             any_low;
  logic [1:0]       low_row;
  logic             same_key;
  logic             cand_row_high;

  function automatic logic [7:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] code;
    case ({row, col})
      4'h0: code = 8'h31;
      4'h1: code = 8'h32;
      4'h2: code = 8'h33;
      4'h3: code = 8'h2B;
      4'h4: code = 8'h34;
      4'h5: code = 8'h35;
      4'h6: code = 8'h36;
      4'h7: code = 8'h2D;
      4'h8: code = 8'h37;
      4'h9: code = 8'h38;
      4'hA: code = 8'h39;
      4'hB: code = 8'h2A;
      4'hC: code = 8'h43;
      4'hD: code = 8'h30;
      4'hE: code = 8'h3D;
      default: code = 8'h08;
    endcase
    return code;
  endfunction

  // Rows are asynchronous to clk, so only the second synchronizer stage is ever used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
    end
  end

  always_comb begin
    tick          = (div_cnt_q == DIV_LAST);
    any_low       = ~&row_s2_q;
    low_row       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s2_q[i]) low_row = 2'(i);
    end
    same_key      = any_low && (low_row == cand_row_q);
    cand_row_high = row_s2_q[cand_row_q];
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    col_idx_d   = col_idx_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    match_cnt_d = match_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    btn_valid_d = 1'b0;
    btn_char_d  = btn_char_q;
    key_held_d  = key_held_q;

    case (state_q)
      S_SCAN: begin
        if (tick) begin
          if (any_low) begin
            cand_row_d  = low_row;
            cand_col_d  = col_idx_q;
            match_cnt_d = 4'd1;
            state_d     = S_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end

      S_DEBOUNCE: begin
        if (tick) begin
          if (same_key) begin
            if (match_cnt_q + 4'd1 == DB_TARGET) begin
              btn_valid_d = 1'b1;
              btn_char_d  = key_map(cand_row_q, cand_col_q);
              key_held_d  = 1'b1;
              rel_cnt_d   = 4'd0;
              state_d     = S_HOLD;
            end
            match_cnt_d = match_cnt_q + 4'd1;
          end else begin
            match_cnt_d = 4'd0;
            state_d     = S_SCAN;
          end
        end
      end

      S_HOLD: begin
        // Only the candidate's own row matters; a short high blip is forgiven.
        if (tick) begin
          if (cand_row_high) begin
            if (rel_cnt_q + 4'd1 == DB_TARGET) begin
              key_held_d  = 1'b0;
              rel_cnt_d   = 4'd0;
              match_cnt_d = 4'd0;
              state_d     = S_SCAN;
            end else begin
              rel_cnt_d = rel_cnt_q + 4'd1;
            end
          end else begin
            rel_cnt_d = 4'd0;
          end
        end
      end

      default: begin
        state_d = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SCAN;
      div_cnt_q   <= '0;
      col_idx_q   <= 2'd0;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      match_cnt_q <= 4'd0;
      rel_cnt_q   <= 4'd0;
      btn_valid_q <= 1'b0;
      btn_char_q  <= 8'h00;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      col_idx_q   <= col_idx_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      match_cnt_q <= match_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      btn_valid_q <= btn_valid_d;
      btn_char_q  <= btn_char_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_idx_q);
  assign btn_valid = btn_valid_q;
  assign btn_char  = btn_char_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/calc_keypad_scan.md
Name: calc_keypad_scan

Overview:
Matrix-keypad front end for the calculator. It scans a 4x4 active-low key matrix and debounces presses. Each debounced press produces exactly one single-cycle btn_valid pulse with its ASCII/control code on btn_char. These outputs drive the calculator FSM's btn_valid/btn_char inputs directly.

Parameters:
SCAN_DIV, 100000, clock cycles each column is driven per scan step (must be >= 4)
DEBOUNCE_SCANS, 4, consecutive matching samples needed to accept a press or a release (must be >= 2, at most 15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
col_out  output  4  keypad column drive, active-low, exactly one bit low at all times
btn_valid  output  1  one-cycle pulse per accepted key press
btn_char  output  8  key code, valid when btn_valid=1, holds last value otherwise
key_held  output  1  high from accepted press until accepted release

Behaviour:
- Reset, asynchronous active-low; applies immediately, including mid-debounce or mid-hold:
  - col_out=4'b1110
  - btn_valid=0, btn_char=8'h00, key_held=0
  - state=S_SCAN, all counters 0, synchronizer flops 4'b1111
- row_in passes through a 2-flop synchronizer before any use.
- Dwell counter:
  - Counts 0..SCAN_DIV-1 while a column is driven.
  - A "sample tick" is the cycle the counter equals SCAN_DIV-1. The synchronized rows are evaluated on that cycle.
- Key map (row r, col c) -> btn_char:
  - r0: '1'(31) '2'(32) '3'(33) '+'(2B)
  - r1: '4'(34) '5'(35) '6'(36) '-'(2D)
  - r2: '7'(37) '8'(38) '9'(39) '*'(2A)
  - r3: 'C'(43) '0'(30) '='(3D) BS(08)
- Multiple rows low in the sampled column: the lowest row index wins.
- FSM states and transitions:
  - S_SCAN:
    - At each sample tick with all rows high, rotate the low bit of col_out: 1110->1101->1011->0111->1110, and reset the dwell counter.
    - At a sample tick with any row low: latch cand_key={row,col}, set match_cnt=1, and go to S_DEBOUNCE. The column is not rotated.
  - S_DEBOUNCE:
    - The column stays fixed. At each sample tick, compare against cand_key.
    - Same key: match_cnt+1. When match_cnt reaches DEBOUNCE_SCANS:
      - pulse btn_valid=1 for exactly the next cycle
      - set btn_char=map(cand_key)
      - set key_held=1
      - go to S_HOLD with rel_cnt=0
    - Different key or all rows high: go to S_SCAN and resume rotation from the current column at the next sample tick. No pulse.
  - S_HOLD:
    - The column stays fixed. No further pulses, however long the key is held (no auto-repeat).
    - At each sample tick with cand_key's row high: rel_cnt+1. With that row low: rel_cnt=0 (a release glitch is tolerated).
    - When rel_cnt reaches DEBOUNCE_SCANS: key_held=0, go to S_SCAN.
    - A different row pressed in the same column during S_HOLD is ignored until release completes.
- Keys in other columns are invisible while in S_DEBOUNCE or S_HOLD. Only one key is registered at a time.
- Latency, for a key stably pressed before its column's sample tick:
  - btn_valid rises 1 cycle after the sample tick that reaches match_cnt=DEBOUNCE_SCANS.
  - That is (DEBOUNCE_SCANS-1)*SCAN_DIV cycles after the first detection tick, plus 1.
- btn_valid is never high on two consecutive cycles. btn_char changes only in the cycle btn_valid rises.

Test Plan:
- Test parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_SCANS=3, rows idle 4'b1111.
- Reset/scan: release rst_n -> col_out=1110, btn_valid=0, btn_char=00, key_held=0. col_out steps 1110->1101->1011->0111->1110, each held 4 cycles, 16-cycle period.
- Clean press '5' (row1 low whenever col_out=1101), held 500 cycles -> exactly one btn_valid pulse with btn_char=8'h35, 9 cycles after the first detection tick. key_held=1 until 3 release samples after row1 goes high. No second pulse.
- Bounce: row0 low under col0 for only 2 consecutive sample ticks, then high -> no btn_valid, key_held stays 0, and scanning resumes.
- Release glitch: hold '=' (row3, col2), release for 1 sample, re-press, then release fully -> exactly one pulse, btn_char=8'h3D. A second clean press afterwards -> a second pulse, 8'h3D.
- Priority/control keys:
  - row0 and row2 both low under col3 -> one pulse, btn_char=8'h2B.
  - row3 alone under col3 -> btn_char=8'h08.
  - row3 under col0 -> btn_char=8'h43.
- Async reset mid-debounce: assert rst_n low after match_cnt=2 -> outputs reset within the same cycle (no clock edge needed). After reset release with the key still held, one pulse occurs only after 3 fresh matching samples.
